// File: rtl/fft_pkg.sv
// Shared constants, FSM encoding and the butterfly address helper for the
// 256-point radix-2 DIF FFT stage sequencer.
package fft_pkg;
  localparam int LOG2N  = 8;
  localparam int N      = 1 << LOG2N;
  localparam int HALF   = N / 2;
  localparam int ADDR_W = LOG2N;
  localparam int STG_W  = 3;
  localparam int TW_W   = LOG2N - 1;
  localparam int BF_W   = 2 * ADDR_W + TW_W;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ISSUE = 3'd1;
  localparam logic [2:0] ST_DRAIN = 3'd2;
  localparam logic [2:0] ST_NEXT  = 3'd3;
  localparam logic [2:0] ST_FIN   = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_ISSUE = ST_ISSUE,
    S_DRAIN = ST_DRAIN,
    S_NEXT  = ST_NEXT,
    S_FIN   = ST_FIN
  } state_e;

  // Returns {addr_a, addr_b, tw_addr}; the butterfly span bit is k = LOG2N-1-stage.
  function automatic logic [BF_W-1:0] bf_addr(input logic [TW_W-1:0]  j,
                                              input logic [STG_W-1:0] stage);
    logic [STG_W-1:0]  k;
    logic [ADDR_W-1:0] jx;
    logic [ADDR_W-1:0] mask;
    logic [ADDR_W-1:0] a;
    logic [ADDR_W-1:0] b;
    logic [TW_W-1:0]   tw;
    k    = STG_W'(LOG2N - 1) - stage;
    jx   = {1'b0, j};
    mask = (ADDR_W'(1) << k) - ADDR_W'(1);
    a    = ((jx & ~mask) << 1) | (jx & mask);
    b    = a | (ADDR_W'(1) << k);
    tw   = TW_W'((jx & mask) << stage);
    return {a, b, tw};
  endfunction
endpackage

// File: rtl/fft_stage_sequencer_if.sv
// Handshake and status bundle between the stage sequencer and the butterfly
// datapath. The sequencer side is the slave modport.
interface fft_stage_sequencer_if;
  import fft_pkg::*;

  // One operand transfer happens on a rising clk edge where bf_valid & bf_ready;
  // once bf_valid rises, addr_a/addr_b/tw_addr/bf_valid hold until that transfer.
  logic              start;
  logic              abort;
  logic              bf_ready;
  logic              wb_valid;
  logic              bf_valid;
  logic [ADDR_W-1:0] addr_a;
  logic [ADDR_W-1:0] addr_b;
  logic [TW_W-1:0]   tw_addr;
  logic [STG_W-1:0]  stage;
  logic              rd_bank;
  logic              busy;
  logic              done;
  logic              wb_err;
  state_e            dbg_state;

  modport slave (
    input  start, abort, bf_ready, wb_valid,
    output bf_valid, addr_a, addr_b, tw_addr, stage, rd_bank, busy, done, wb_err,
           dbg_state
  );

  modport master (
    output start, abort, bf_ready, wb_valid,
    input  bf_valid, addr_a, addr_b, tw_addr, stage, rd_bank, busy, done, wb_err,
           dbg_state
  );
endinterface

// File: rtl/fft_bf_addr_gen.sv
// Combinational butterfly index/stage to operand and twiddle address mapping.
module fft_bf_addr_gen
  import fft_pkg::*;
(
  input  logic [TW_W-1:0]   i_j,
  input  logic [STG_W-1:0]  i_stage,
  output logic [ADDR_W-1:0] o_addr_a,
  output logic [ADDR_W-1:0] o_addr_b,
  output logic [TW_W-1:0]   o_tw_addr
);
  logic [BF_W-1:0] w_addr;

  assign w_addr = bf_addr(i_j, i_stage);
  assign {o_addr_a, o_addr_b, o_tw_addr} = w_addr;
endmodule

// File: rtl/fft_stage_sequencer.sv
// Sequences the radix-2 DIF stages: issues N/2 butterflies per stage, waits for
// all write-backs, flips the ping-pong bank and pulses done after the last stage.
module fft_stage_sequencer
  import fft_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  fft_stage_sequencer_if.slave  bus
);
  localparam logic [ADDR_W-1:0] J_LAST   = ADDR_W'(HALF - 1);
  localparam logic [ADDR_W-1:0] CNT_FULL = ADDR_W'(HALF);
  localparam logic [STG_W-1:0]  STG_LAST = STG_W'(LOG2N - 1);

  logic [2:0]        r_state;
  logic [2:0]        w_state_nxt;
  logic [ADDR_W-1:0] r_j;
  logic [ADDR_W-1:0] w_j_nxt;
  logic [ADDR_W-1:0] r_wb_cnt;
  logic [ADDR_W-1:0] w_wb_cnt_nxt;
  logic [STG_W-1:0]  r_stage;
  logic [STG_W-1:0]  w_stage_nxt;
  logic              r_bank;
  logic              w_bank_nxt;
  logic              r_busy;
  logic              w_busy_nxt;
  logic              r_valid;
  logic              w_valid_nxt;
  logic              r_done;
  logic              w_done_nxt;
  logic              r_err;
  logic              w_err_nxt;
  logic [ADDR_W-1:0] r_addr_a;
  logic [ADDR_W-1:0] r_addr_b;
  logic [TW_W-1:0]   r_tw;
  logic [ADDR_W-1:0] w_addr_a;
  logic [ADDR_W-1:0] w_addr_b;
  logic [TW_W-1:0]   w_tw;
  logic              w_xfer;
  logic              w_in_stage;

  assign w_xfer     = r_valid & bus.bf_ready;
  assign w_in_stage = (r_state == ST_ISSUE) || (r_state == ST_DRAIN);

  // Addresses are computed for the next j/stage so the output registers are
  // already correct in the cycle bf_valid is presented.
  fft_bf_addr_gen u_addr_gen (
    .i_j       (w_j_nxt[TW_W-1:0]),
    .i_stage   (w_stage_nxt),
    .o_addr_a  (w_addr_a),
    .o_addr_b  (w_addr_b),
    .o_tw_addr (w_tw)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_j_nxt      = r_j;
    w_wb_cnt_nxt = r_wb_cnt;
    w_stage_nxt  = r_stage;
    w_bank_nxt   = r_bank;
    w_busy_nxt   = r_busy;
    w_valid_nxt  = r_valid;
    w_done_nxt   = 1'b0;
    w_err_nxt    = r_err;

    // A write-back landing in the same cycle as an issue is legitimate.
    if (bus.wb_valid) begin
      if (w_in_stage && ((r_wb_cnt != r_j) || w_xfer)) begin
        w_wb_cnt_nxt = r_wb_cnt + ADDR_W'(1);
      end else begin
        w_err_nxt = 1'b1;
      end
    end

    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_state_nxt  = ST_ISSUE;
          w_stage_nxt  = '0;
          w_j_nxt      = '0;
          w_wb_cnt_nxt = '0;
          w_bank_nxt   = 1'b0;
          w_busy_nxt   = 1'b1;
          w_valid_nxt  = 1'b1;
        end
      end
      ST_ISSUE: begin
        if (w_xfer) begin
          w_j_nxt = r_j + ADDR_W'(1);
          if (r_j == J_LAST) begin
            w_state_nxt = ST_DRAIN;
            w_valid_nxt = 1'b0;
          end
        end
      end
      ST_DRAIN: begin
        if (r_wb_cnt == CNT_FULL) begin
          if (r_stage == STG_LAST) begin
            w_state_nxt = ST_FIN;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = ST_NEXT;
          end
        end
      end
      ST_NEXT: begin
        w_state_nxt  = ST_ISSUE;
        w_stage_nxt  = r_stage + STG_W'(1);
        w_bank_nxt   = ~r_bank;
        w_j_nxt      = '0;
        w_wb_cnt_nxt = '0;
        w_valid_nxt  = 1'b1;
      end
      ST_FIN: begin
        w_state_nxt = ST_IDLE;
        w_busy_nxt  = 1'b0;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_busy_nxt  = 1'b0;
        w_valid_nxt = 1'b0;
      end
    endcase

    if (bus.abort) begin
      w_state_nxt = ST_IDLE;
      w_busy_nxt  = 1'b0;
      w_valid_nxt = 1'b0;
      w_done_nxt  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_j      <= '0;
      r_wb_cnt <= '0;
      r_stage  <= '0;
      r_bank   <= 1'b0;
      r_busy   <= 1'b0;
      r_valid  <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_addr_a <= '0;
      r_addr_b <= '0;
      r_tw     <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_j      <= w_j_nxt;
      r_wb_cnt <= w_wb_cnt_nxt;
      r_stage  <= w_stage_nxt;
      r_bank   <= w_bank_nxt;
      r_busy   <= w_busy_nxt;
      r_valid  <= w_valid_nxt;
      r_done   <= w_done_nxt;
      r_err    <= w_err_nxt;
      if (w_valid_nxt) begin
        r_addr_a <= w_addr_a;
        r_addr_b <= w_addr_b;
        r_tw     <= w_tw;
      end
    end
  end

  assign bus.bf_valid  = r_valid;
  assign bus.addr_a    = r_addr_a;
  assign bus.addr_b    = r_addr_b;
  assign bus.tw_addr   = r_tw;
  assign bus.stage     = r_stage;
  assign bus.rd_bank   = r_bank;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.wb_err    = r_err;
  assign bus.dbg_state = state_e'(r_state);
endmodule
